// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4
`else
    S_WRITE = 3'd3
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: holds the first three bytes of a word and
// presents the full word combinationally alongside the fourth byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[15:0], byte_i};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // The count wraps to zero on the fourth byte, so consecutive words need no explicit clear.
  assign word_o     = {sr_q, byte_i};
  assign complete_o = shift_i && !clr_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, big-endian program into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to append and verify an XOR checksum word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic        pk_clr;
  logic        xfer;
  logic [31:0] pk_word;
  logic        pk_complete;

  assign xfer    = in_valid && in_ready;
  assign idx_inc = idx_q + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (pk_clr),
    .shift_i    (xfer),
    .byte_i     (in_data),
    .word_o     (pk_word),
    .complete_o (pk_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = done_q;
    error_d  = error_q;
    pk_clr   = 1'b0;
    in_ready = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          pk_clr  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_HDR: begin
        in_ready = 1'b1;
        if (pk_complete) begin
          if (pk_word == 32'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (pk_word > MAX_WORDS_W) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            len_d   = pk_word[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end

      // Address and data are captured here so they are stable through WRITE and held afterwards.
      S_DATA: begin
        in_ready = 1'b1;
        if (pk_complete) begin
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = pk_word;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        idx_d = idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ wdata_q;
`endif
        if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (pk_complete) begin
          if (pk_word != csum_q) begin
            error_d = 1'b1;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule
